// File: rtl/load_use_stall_unit_if.sv
// Pipeline-control bundle between the ID-stage stall unit and the datapath.
// master: the pipeline datapath (drives ID/MEM/EX status, consumes enables).
// slave : the stall unit (consumes status, drives enables and statistics).
// Handshake: there is no valid/ready pair here; every signal is a same-cycle
// level. The datapath presents status each cycle and the unit answers with
// enables combinationally in that same cycle; registers act on the next edge.
interface load_use_stall_unit_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_W    = 16
) ();
  // ID-stage instruction description
  logic                id_valid;
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic                id_is_store;
  logic                id_is_load;
  logic [REG_BITS-1:0] id_dest;
  // MEM / EX status
  logic                mem_access;
  logic                mem_ready;
  logic                branch_taken;
  // Pipeline control outputs
  logic                pc_write;
  logic                ifid_write;
  logic                ifid_flush;
  logic                idex_bubble;
  logic                freeze;
  logic                mem_timeout;
  logic [CNT_W-1:0]    lu_stalls;
  logic [CNT_W-1:0]    mem_stalls;
  // FSM state for observation: 0 = RUN, 1 = MEM_WAIT
  logic                dbg_state;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_store,
           id_is_load, id_dest, mem_access, mem_ready, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, freeze,
           mem_timeout, lu_stalls, mem_stalls, dbg_state
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_store,
           id_is_load, id_dest, mem_access, mem_ready, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, freeze,
           mem_timeout, lu_stalls, mem_stalls, dbg_state
  );
endinterface

// File: rtl/load_use_stall_unit.sv
// Stall/bubble generator for the 5-stage MIPS pipeline.
// Inserts one bubble on an unforwardable load-use hazard, freezes the pipe
// while data memory is busy, and squashes IF/ID + ID/EX on a taken branch.
// Priority: freeze > flush > load-use. Tracks the EX instruction internally.
module load_use_stall_unit #(
  parameter int REG_BITS   = 5,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  load_use_stall_unit_if.slave bus
);

  localparam int WC_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(WAIT_LIMIT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                ex_valid_q, ex_valid_d;
  logic                ex_is_load_q, ex_is_load_d;
  logic [REG_BITS-1:0] ex_dest_q, ex_dest_d;
  logic                br_pend_q, br_pend_d;
  logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]    mem_cnt_q, mem_cnt_d;

  logic lu, mem_wait, br_eff;
  logic pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, freeze_c;

  // Hazard detection: rt of a store is pure store data and is forwarded,
  // so it never causes a stall; $0 never creates a dependency.
  always_comb begin
    lu = bus.id_valid & ex_valid_q & ex_is_load_q & (ex_dest_q != '0) &
         ((bus.id_uses_rs & (bus.id_rs == ex_dest_q)) |
          (bus.id_uses_rt & ~bus.id_is_store & (bus.id_rt == ex_dest_q)));
    mem_wait = bus.mem_access & ~bus.mem_ready;
    // A branch that arrived while frozen is honoured on the release cycle.
    br_eff = bus.branch_taken | br_pend_q;
  end

  // Next-state, EX record, counters and pipeline enables with fixed priority.
  always_comb begin
    state_d       = RUN;
    ex_valid_d    = ex_valid_q;
    ex_is_load_d  = ex_is_load_q;
    ex_dest_d     = ex_dest_q;
    br_pend_d     = 1'b0;
    wait_cnt_d    = '0;
    timeout_d     = timeout_q;
    lu_cnt_d      = lu_cnt_q;
    mem_cnt_d     = mem_cnt_q;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    freeze_c      = 1'b0;

    if (mem_wait) begin
      // Whole pipe holds; EX record stays as it is.
      state_d      = MEM_WAIT;
      freeze_c     = 1'b1;
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      br_pend_d    = br_eff;
      wait_cnt_d   = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
      if (mem_cnt_q != '1) mem_cnt_d = mem_cnt_q + 1'b1;
    end else if (br_eff) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
      ex_valid_d    = 1'b0;
      ex_is_load_d  = 1'b0;
      ex_dest_d     = '0;
    end else if (lu) begin
      // Bubble enters EX, so the hazard cannot re-trigger next cycle.
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
      ex_valid_d    = 1'b0;
      ex_is_load_d  = 1'b0;
      ex_dest_d     = '0;
      if (lu_cnt_q != '1) lu_cnt_d = lu_cnt_q + 1'b1;
    end else begin
      ex_valid_d   = bus.id_valid;
      ex_is_load_d = bus.id_is_load;
      ex_dest_d    = bus.id_dest;
    end

    if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;
  end

  // State and statistics registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      ex_valid_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_dest_q    <= '0;
      br_pend_q    <= 1'b0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      lu_cnt_q     <= '0;
      mem_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ex_valid_q   <= ex_valid_d;
      ex_is_load_q <= ex_is_load_d;
      ex_dest_q    <= ex_dest_d;
      br_pend_q    <= br_pend_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
      lu_cnt_q     <= lu_cnt_d;
      mem_cnt_q    <= mem_cnt_d;
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.ifid_write  = ifid_write_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_bubble = idex_bubble_c;
  assign bus.freeze      = freeze_c;
  assign bus.mem_timeout = timeout_q;
  assign bus.lu_stalls   = lu_cnt_q;
  assign bus.mem_stalls  = mem_cnt_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_load_use_stall_unit.sv
// Directed bench for load_use_stall_unit. Each scenario task drives the ID/MEM
// status, lets it settle, and compares the combinational enables
// {pc_write, ifid_write, ifid_flush, idex_bubble, freeze} plus counters.
module tb_load_use_stall_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  load_use_stall_unit_if #(.REG_BITS(5), .CNT_W(16)) bus ();

  load_use_stall_unit #(.REG_BITS(5), .WAIT_LIMIT(15), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-enable encodings {pc, ifid, flush, bubble, freeze}
  localparam logic [4:0] HZ_RUN    = 5'b11000;
  localparam logic [4:0] HZ_LU     = 5'b00010;
  localparam logic [4:0] HZ_FREEZE = 5'b00001;
  localparam logic [4:0] HZ_FLUSH  = 5'b11110;

  function automatic logic [4:0] hz();
    return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.freeze};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic st,
                          input logic ld, input logic [4:0] dest);
    bus.id_valid    = v;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
    bus.id_is_store = st;
    bus.id_is_load  = ld;
    bus.id_dest     = dest;
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_access   = 1'b0;
    bus.mem_ready    = 1'b1;
    bus.branch_taken = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    vectors++;
    if (hz() !== HZ_RUN) begin
      miscompares++; $display("FAIL reset_enables got %b exp %b", hz(), HZ_RUN);
    end
    vectors++;
    if ({bus.mem_timeout, bus.dbg_state} !== 2'b00) begin
      miscompares++; $display("FAIL reset_timeout_state got %b exp 00", {bus.mem_timeout, bus.dbg_state});
    end
    vectors++;
    if ({bus.lu_stalls, bus.mem_stalls} !== 32'd0) begin
      miscompares++; $display("FAIL reset_counters got %0d/%0d exp 0/0", bus.lu_stalls, bus.mem_stalls);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_id(1, 5'd1, 5'd5, 1, 0, 0, 1, 5'd5);           // lw $5,0($1)
    vectors++;
    if (hz() !== HZ_RUN) begin
      miscompares++; $display("FAIL lu_lw_issue got %b exp %b", hz(), HZ_RUN);
    end
    step();
    drive_id(1, 5'd5, 5'd7, 1, 1, 0, 0, 5'd6);           // add $6,$5,$7
    vectors++;
    if (hz() !== HZ_LU) begin
      miscompares++; $display("FAIL lu_bubble got %b exp %b", hz(), HZ_LU);
    end
    step();
    vectors++;
    if (hz() !== HZ_RUN) begin
      miscompares++; $display("FAIL lu_add_issues got %b exp %b", hz(), HZ_RUN);
    end
    vectors++;
    if (bus.lu_stalls !== 16'd1) begin
      miscompares++; $display("FAIL lu_count got %0d exp 1", bus.lu_stalls);
    end
    step();
  endtask

  task automatic test_store_data();
    do_reset();
    drive_id(1, 5'd1, 5'd5, 1, 0, 0, 1, 5'd5);           // lw $5
    step();
    drive_id(1, 5'd8, 5'd5, 1, 1, 1, 0, 5'd0);           // sw $5,0($8)
    vectors++;
    if (hz() !== HZ_RUN) begin
      miscompares++; $display("FAIL sw_data_no_stall got %b exp %b", hz(), HZ_RUN);
    end
    step();
    drive_id(1, 5'd1, 5'd5, 1, 0, 0, 1, 5'd5);           // lw $5
    step();
    drive_id(1, 5'd5, 5'd9, 1, 1, 1, 0, 5'd0);           // sw $9,0($5)
    vectors++;
    if (hz() !== HZ_LU) begin
      miscompares++; $display("FAIL sw_base_bubble got %b exp %b", hz(), HZ_LU);
    end
    step();
    vectors++;
    if (bus.lu_stalls !== 16'd1) begin
      miscompares++; $display("FAIL sw_count got %0d exp 1", bus.lu_stalls);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    drive_id(1, 5'd1, 5'd0, 1, 0, 0, 1, 5'd0);           // lw $0
    step();
    drive_id(1, 5'd0, 5'd0, 1, 1, 0, 0, 5'd6);           // add $6,$0,$0
    vectors++;
    if (hz() !== HZ_RUN) begin
      miscompares++; $display("FAIL zero_reg got %b exp %b", hz(), HZ_RUN);
    end
    step();
    drive_id(1, 5'd1, 5'd5, 1, 0, 0, 1, 5'd5);           // lw $5
    step();
    drive_id(1, 5'd5, 5'd5, 0, 0, 0, 0, 5'd0);           // j (fields alias $5, unused)
    vectors++;
    if (hz() !== HZ_RUN) begin
      miscompares++; $display("FAIL jump_no_use got %b exp %b", hz(), HZ_RUN);
    end
    step();
    drive_id(1, 5'd1, 5'd5, 1, 0, 0, 1, 5'd5);           // lw $5
    step();
    drive_id(0, 5'd5, 5'd5, 1, 1, 0, 0, 5'd6);           // invalid slot
    vectors++;
    if (hz() !== HZ_RUN) begin
      miscompares++; $display("FAIL invalid_id got %b exp %b", hz(), HZ_RUN);
    end
    step();
    vectors++;
    if (bus.lu_stalls !== 16'd0) begin
      miscompares++; $display("FAIL no_hazard_count got %0d exp 0", bus.lu_stalls);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_id(1, 5'd1, 5'd5, 1, 0, 0, 1, 5'd5);           // lw $5
    step();
    drive_id(1, 5'd5, 5'd6, 1, 0, 0, 1, 5'd6);           // lw $6,0($5)
    vectors++;
    if (hz() !== HZ_LU) begin
      miscompares++; $display("FAIL b2b_first got %b exp %b", hz(), HZ_LU);
    end
    step();
    vectors++;
    if (hz() !== HZ_RUN) begin
      miscompares++; $display("FAIL b2b_release got %b exp %b", hz(), HZ_RUN);
    end
    step();
    drive_id(1, 5'd2, 5'd6, 1, 1, 0, 0, 5'd7);           // add $7,$2,$6 (rt hazard)
    vectors++;
    if (hz() !== HZ_LU) begin
      miscompares++; $display("FAIL b2b_second got %b exp %b", hz(), HZ_LU);
    end
    step();
    vectors++;
    if (bus.lu_stalls !== 16'd2) begin
      miscompares++; $display("FAIL b2b_count got %0d exp 2", bus.lu_stalls);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive_id(1, 5'd1, 5'd5, 1, 0, 0, 1, 5'd5);           // lw $5
    step();
    bus.mem_access = 1'b1;
    bus.mem_ready  = 1'b0;
    drive_id(1, 5'd5, 5'd7, 1, 1, 0, 0, 5'd6);           // add $6,$5,$7
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (hz() !== HZ_FREEZE) begin
        miscompares++; $display("FAIL wait_freeze cyc%0d got %b exp %b", i, hz(), HZ_FREEZE);
      end
      vectors++;
      if (bus.mem_stalls !== 16'(i)) begin
        miscompares++; $display("FAIL wait_count cyc%0d got %0d exp %0d", i, bus.mem_stalls, i);
      end
      step();
    end
    vectors++;
    if (bus.dbg_state !== 1'b1) begin
      miscompares++; $display("FAIL wait_state got %b exp 1", bus.dbg_state);
    end
    bus.mem_ready = 1'b1;
    #1;
    // EX record (lw $5) was held, so the add now takes its bubble.
    vectors++;
    if (hz() !== HZ_LU) begin
      miscompares++; $display("FAIL wait_release got %b exp %b", hz(), HZ_LU);
    end
    vectors++;
    if (bus.mem_stalls !== 16'd3) begin
      miscompares++; $display("FAIL wait_total got %0d exp 3", bus.mem_stalls);
    end
    step();
    bus.mem_access = 1'b0;
    #1;
    vectors++;
    if ({bus.dbg_state, bus.lu_stalls} !== {1'b0, 16'd1}) begin
      miscompares++; $display("FAIL wait_after got st=%b lu=%0d exp st=0 lu=1", bus.dbg_state, bus.lu_stalls);
    end
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.mem_access = 1'b1;
    bus.mem_ready  = 1'b0;
    #1;
    for (int i = 1; i <= 16; i++) begin
      vectors++;
      if (bus.mem_timeout !== (i == 16)) begin
        miscompares++; $display("FAIL timeout cyc%0d got %b exp %b", i, bus.mem_timeout, (i == 16));
      end
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    vectors++;
    if ({hz(), bus.mem_timeout, bus.mem_stalls} !== {HZ_RUN, 1'b1, 16'd16}) begin
      miscompares++; $display("FAIL timeout_sticky got hz=%b to=%b ms=%0d exp hz=%b to=1 ms=16",
                              hz(), bus.mem_timeout, bus.mem_stalls, HZ_RUN);
    end
    step();
    bus.mem_ready = 1'b0;
    #1;
    step();
    // Reset in the middle of a freeze
    rst_n = 1'b0;
    bus.mem_access = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({hz(), bus.mem_timeout, bus.dbg_state, bus.mem_stalls} !== {HZ_RUN, 1'b0, 1'b0, 16'd0}) begin
      miscompares++; $display("FAIL timeout_reset got hz=%b to=%b st=%b ms=%0d exp %b/0/0/0",
                              hz(), bus.mem_timeout, bus.dbg_state, bus.mem_stalls, HZ_RUN);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive_id(1, 5'd1, 5'd5, 1, 0, 0, 1, 5'd5);           // lw $5
    step();
    bus.branch_taken = 1'b1;
    drive_id(1, 5'd5, 5'd7, 1, 1, 0, 0, 5'd6);           // add $6,$5,$7 + branch
    vectors++;
    if (hz() !== HZ_FLUSH) begin
      miscompares++; $display("FAIL branch_flush got %b exp %b", hz(), HZ_FLUSH);
    end
    step();
    bus.branch_taken = 1'b0;
    #1;
    vectors++;
    if ({hz(), bus.lu_stalls} !== {HZ_RUN, 16'd0}) begin
      miscompares++; $display("FAIL branch_no_bubble got hz=%b lu=%0d exp %b/0", hz(), bus.lu_stalls, HZ_RUN);
    end
    step();
  endtask

  task automatic test_branch_pending();
    do_reset();
    bus.mem_access   = 1'b1;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b1;
    #1;
    vectors++;
    if (hz() !== HZ_FREEZE) begin
      miscompares++; $display("FAIL brpend_freeze got %b exp %b", hz(), HZ_FREEZE);
    end
    step();
    bus.branch_taken = 1'b0;
    #1;
    step();
    bus.mem_ready = 1'b1;
    #1;
    vectors++;
    if (hz() !== HZ_FLUSH) begin
      miscompares++; $display("FAIL brpend_release got %b exp %b", hz(), HZ_FLUSH);
    end
    step();
    bus.mem_access = 1'b0;
    #1;
    vectors++;
    if (hz() !== HZ_RUN) begin
      miscompares++; $display("FAIL brpend_after got %b exp %b", hz(), HZ_RUN);
    end
  endtask

  // Sequencer and final report
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_store_data();
    test_no_hazard();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_branch();
    test_branch_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
